// File: rtl/border_scan.sv
// Purpose : raster-scan pixel sequencer with per-side border flags for the depthwise-conv padding muxes.
// Latency : first beat is valid 1 clk after go is accepted; one beat per cycle while out_ready is high.
// Backpr. : out_valid && !out_ready freezes i/row/col/prov/last; the scan resumes on the next ready cycle.
//
// Ports: clk, rst_n (async active-low); go/matrix/stride2 start a scan of an MxM map from IDLE;
//        out_valid/out_ready stream carrying i (row*M+col), row, col, prov {top,bottom,left,right}, last;
//        busy is high while scanning, done pulses one cycle after the final beat is accepted.
// Optional feature: define BORDER_SCAN_STRIDE2_EN to honour stride2 (even rows/cols only);
//        without it stride2 is ignored and the scan is always stride 1.
module border_scan #(
  parameter int SIZE_W = 7,
  parameter int IDX_W  = 15,
  parameter int PAD    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [SIZE_W-1:0] matrix,
  input  logic              stride2,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  i,
  output logic [SIZE_W-1:0] row,
  output logic [SIZE_W-1:0] col,
  output logic [3:0]        prov,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SIZE_W-1:0] m_q, m_d;
  logic [SIZE_W-1:0] row_q, row_d;
  logic [SIZE_W-1:0] col_q, col_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [3:0]        prov_q, prov_d;
  logic              last_q, last_d;

  logic stride_eff;  // stride mode of the scan in progress
  logic stride_go;   // stride mode requested alongside go

`ifdef BORDER_SCAN_STRIDE2_EN
  logic stride_q, stride_d;
  assign stride_eff = stride_q;
  assign stride_go  = stride2;
`else
  logic unused_stride2;
  assign unused_stride2 = stride2;
  assign stride_eff     = 1'b0;
  assign stride_go      = 1'b0;
`endif

  // Flags are compared one bit wider than the map so that M + PAD cannot wrap.
  function automatic logic [3:0] border_flags(input logic [SIZE_W-1:0] r,
                                              input logic [SIZE_W-1:0] c,
                                              input logic [SIZE_W-1:0] m);
    logic [SIZE_W:0] re, ce, me, pe;
    re = {1'b0, r};
    ce = {1'b0, c};
    me = {1'b0, m};
    pe = (SIZE_W+1)'(PAD);
    return {re < pe, (re + pe) >= me, ce < pe, (ce + pe) >= me};
  endfunction

  // Last scanned row/col index: M-1, rounded down to even in stride-2 mode.
  function automatic logic [SIZE_W-1:0] final_pos(input logic [SIZE_W-1:0] m,
                                                  input logic              s);
    logic [SIZE_W-1:0] f;
    f = m - SIZE_W'(1);
    if (s) f[0] = 1'b0;
    return f;
  endfunction

  logic [SIZE_W-1:0] step_s;
  logic [SIZE_W:0]   col_sum;
  logic              wrap;
  logic [SIZE_W-1:0] row_n, col_n;
  logic [IDX_W-1:0]  i_n, row_span;

  always_comb begin
    step_s   = stride_eff ? SIZE_W'(2) : SIZE_W'(1);
    col_sum  = {1'b0, col_q} + {1'b0, step_s};
    wrap     = col_sum >= {1'b0, m_q};
    col_n    = wrap ? '0 : col_sum[SIZE_W-1:0];
    row_n    = wrap ? (row_q + step_s) : row_q;
    // Index distance between vertically adjacent scanned pixels (M or 2M).
    row_span = stride_eff ? IDX_W'({m_q, 1'b0}) : IDX_W'(m_q);
    // On wrap, rewind to column 0 of this row, then jump down by row_span.
    i_n      = wrap ? (i_q - IDX_W'(col_q) + row_span) : (i_q + IDX_W'(step_s));
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    i_d     = i_q;
    prov_d  = prov_q;
    last_d  = last_q;
`ifdef BORDER_SCAN_STRIDE2_EN
    stride_d = stride_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go) begin
          m_d = matrix;
          if (matrix != '0) begin
            state_d = S_RUN;
            row_d   = '0;
            col_d   = '0;
            i_d     = '0;
            prov_d  = border_flags('0, '0, matrix);
            last_d  = final_pos(matrix, stride_go) == '0;
`ifdef BORDER_SCAN_STRIDE2_EN
            stride_d = stride2;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
            row_d   = '0;
            col_d   = '0;
            i_d     = '0;
            prov_d  = '0;
            last_d  = 1'b0;
          end else begin
            row_d  = row_n;
            col_d  = col_n;
            i_d    = i_n;
            prov_d = border_flags(row_n, col_n, m_q);
            last_d = (row_n == final_pos(m_q, stride_eff)) &&
                     (col_n == final_pos(m_q, stride_eff));
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      i_q     <= '0;
      prov_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      row_q   <= row_d;
      col_q   <= col_d;
      i_q     <= i_d;
      prov_q  <= prov_d;
      last_q  <= last_d;
    end
  end

`ifdef BORDER_SCAN_STRIDE2_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stride_q <= 1'b0;
    else        stride_q <= stride_d;
  end
`endif

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign i         = i_q;
  assign row       = row_q;
  assign col       = col_q;
  assign prov      = prov_q;
  assign last      = last_q;

endmodule

// File: tb/tb_border_scan.sv
module tb_border_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [6:0]  matrix = '0;
  logic        stride2 = 1'b0;
  logic        out_ready = 1'b0;

  logic        v1, last1, busy1, done1;
  logic [14:0] i1;
  logic [6:0]  row1, col1;
  logic [3:0]  prov1;
  logic        v2, last2, busy2, done2;
  logic [14:0] i2;
  logic [6:0]  row2, col2;
  logic [3:0]  prov2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  border_scan #(.SIZE_W(7), .IDX_W(15), .PAD(1)) u_pad1 (
    .clk(clk), .rst_n(rst_n), .go(go), .matrix(matrix), .stride2(stride2),
    .out_ready(out_ready), .out_valid(v1), .i(i1), .row(row1), .col(col1),
    .prov(prov1), .last(last1), .busy(busy1), .done(done1));

  border_scan #(.SIZE_W(7), .IDX_W(15), .PAD(2)) u_pad2 (
    .clk(clk), .rst_n(rst_n), .go(go), .matrix(matrix), .stride2(stride2),
    .out_ready(out_ready), .out_valid(v2), .i(i2), .row(row2), .col(col2),
    .prov(prov2), .last(last2), .busy(busy2), .done(done2));

  typedef struct {
    int       idx;
    int       r;
    int       c;
    logic [3:0] p1;
    logic [3:0] p2;
    logic     lst;
  } beat_t;

  function automatic logic [3:0] model_flags(int r, int c, int m, int pad);
    return {r < pad, r + pad >= m, c < pad, c + pad >= m};
  endfunction

  // Runs one scan and checks every visible beat of both instances against the reference list.
  task automatic run_scan(input int m, input bit st, input int mode);
    beat_t q[$];
    beat_t b;
    int    s, lp, budget, cyc;
    bit    rdy, seen_done;
    s = 1;
`ifdef BORDER_SCAN_STRIDE2_EN
    if (st) s = 2;
`endif
    for (int r = 0; r < m; r += s)
      for (int c = 0; c < m; c += s) begin
        b.idx = r * m + c; b.r = r; b.c = c;
        b.p1 = model_flags(r, c, m, 1);
        b.p2 = model_flags(r, c, m, 2);
        b.lst = 1'b0;
        q.push_back(b);
      end
    if (q.size() > 0) q[q.size()-1].lst = 1'b1;

    @(negedge clk);
    go = 1'b1; matrix = 7'(m); stride2 = st; out_ready = 1'b0;
    @(negedge clk);
    go = 1'b0; matrix = 7'($urandom); stride2 = 1'($urandom);
    lp = -1; seen_done = 0; budget = m * m * 4 + 20;
    for (cyc = 0; cyc < budget && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (v1 !== (m != 0)) begin
          errors++;
          $display("FAIL first_beat_latency m=%0d: out_valid=%b required %b", m, v1, m != 0);
        end
      end
      checks++;
      if (busy1 !== v1 || v2 !== v1 || busy2 !== v1 || done2 !== done1) begin
        errors++;
        $display("FAIL handshake m=%0d cyc=%0d: v1=%b busy1=%b v2=%b busy2=%b done1=%b done2=%b",
                 m, cyc, v1, busy1, v2, busy2, done1, done2);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3) == 0;
        default: rdy = 1'($urandom);
      endcase
      if (v1 === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat m=%0d: got i=%0d, required no beat", m, i1);
        end else begin
          b = q[0];
          if (i1 !== 15'(b.idx) || row1 !== 7'(b.r) || col1 !== 7'(b.c) || prov1 !== b.p1 ||
              last1 !== b.lst || i2 !== 15'(b.idx) || row2 !== 7'(b.r) || col2 !== 7'(b.c) ||
              prov2 !== b.p2 || last2 !== b.lst) begin
            errors++;
            $display("FAIL beat m=%0d st=%0d: got i=%0d r=%0d c=%0d p1=%b p2=%b l=%b/%b, required i=%0d r=%0d c=%0d p1=%b p2=%b l=%b",
                     m, st, i1, row1, col1, prov1, prov2, last1, last2, b.idx, b.r, b.c, b.p1, b.p2, b.lst);
          end
          if (rdy) begin
            void'(q.pop_front());
            lp = cyc;
          end
        end
      end
      if (done1 === 1'b1) begin
        seen_done = 1;
        checks++;
        if (cyc != lp + 1 || q.size() != 0) begin
          errors++;
          $display("FAIL done_timing m=%0d: done at cyc %0d with %0d beats left, required cyc %0d with 0 left",
                   m, cyc, q.size(), lp + 1);
        end
        // A go during the done cycle must not start a new scan.
        go = 1'b1; matrix = 7'd3; out_ready = 1'b1;
      end else begin
        out_ready = rdy;
        go = 1'($urandom);
        matrix = 7'($urandom);
        stride2 = 1'($urandom);
      end
    end
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL scan_timeout m=%0d: no done within %0d cycles, %0d beats left", m, budget, q.size());
      go = 1'b0;
    end else begin
      @(negedge clk);
      go = 1'b0;
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || v1 !== 1'b0 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL done_go_ignored m=%0d: done=%b busy=%b valid=%b, required 0 0 0", m, done1, busy1, v1);
      end
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || v1 !== 1'b0 || prov1 !== 4'b0 || i1 !== 15'd0) begin
        errors++;
        $display("FAIL idle_after_done m=%0d: busy=%b valid=%b prov=%b i=%0d, required all 0", m, busy1, v1, prov1, i1);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({v1, i1, row1, col1, prov1, last1, busy1, done1} !== '0 ||
        {v2, i2, row2, col2, prov2, last2, busy2, done2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pad1=%h pad2=%h, required 0",
               {v1, i1, row1, col1, prov1, last1, busy1, done1},
               {v2, i2, row2, col2, prov2, last2, busy2, done2});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_m4;       run_scan(4, 1'b0, 0); endtask
  task automatic test_m1;       run_scan(1, 1'b0, 0); endtask
  task automatic test_m0;       run_scan(0, 1'b0, 0); endtask
  task automatic test_m5_pad2;  run_scan(5, 1'b0, 0); endtask
  task automatic test_backpressure; run_scan(3, 1'b0, 1); endtask
  task automatic test_max_map;  run_scan(127, 1'b0, 0); endtask

  task automatic test_stride2;
    run_scan(5, 1'b1, 0);
    run_scan(6, 1'b1, 1);
    run_scan(2, 1'b1, 0);
  endtask

  task automatic test_reset_mid;
    bit hit;
    hit = 0;
    @(negedge clk);
    go = 1'b1; matrix = 7'd4; stride2 = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (v1 === 1'b1 && i1 === 15'd6) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: beat i=6 not seen, last i=%0d", i1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v1, i1, row1, col1, prov1, last1, busy1, done1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h, required 0", {v1, i1, row1, col1, prov1, last1, busy1, done1});
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: done=%b required 0", done1);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    run_scan(2, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++)
      run_scan($urandom_range(0, 12), 1'($urandom), 2);
  endtask

  initial begin
    test_reset();
    test_m4();
    test_m1();
    test_m0();
    test_m5_pad2();
    test_backpressure();
    test_reset_mid();
    test_stride2();
    test_random();
    test_max_map();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
